// File: rtl/iir_biquad_cascade_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_biquad_cascade_if: sample handshake and coefficient write bus  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface iir_biquad_cascade_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] din;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout;
  logic                     flush;
  logic                     coef_we;
  logic [7:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;

  modport master (
    output in_valid, din, flush, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, flush, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, dout
  );
endinterface
`default_nettype wire

// File: rtl/iir_biquad_cascade.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iir_biquad_cascade: DF1 biquad cascade on one shared MAC           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iir_biquad_cascade #(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int FRAC_BITS    = 14,
  parameter int NUM_SECTIONS = 4,
  parameter int ACC_W        = 36
) (
  input  logic               clk,
  input  logic               rst,
  iir_biquad_cascade_if.slave bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int NCOEF  = 5 * NUM_SECTIONS;
  localparam int CAW    = $clog2(NCOEF);
  localparam int SW     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [SW-1:0]            LAST_S  = SW'(NUM_SECTIONS - 1);
  localparam logic [7:0]               NCOEF_A = 8'(NCOEF);
  localparam logic signed [COEF_W-1:0] UNITY   = COEF_W'(1) << FRAC_BITS;
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(0) - (ACC_W'(1) << (DATA_W - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, STORE = 2'd2} state_t;

  state_t state, state_next;
  logic   accept;

  logic signed [COEF_W-1:0] coef [NCOEF];
  logic signed [DATA_W-1:0] x1 [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x2 [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y1 [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y2 [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x_cur;
  logic signed [ACC_W-1:0]  acc;
  logic [SW-1:0]            s;
  logic [2:0]               t;

  logic signed [COEF_W-1:0] c_sel;
  logic signed [DATA_W-1:0] d_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_base, acc_next, acc_rnd, acc_shr;
  logic signed [DATA_W-1:0] y_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:    if (bus.in_valid) begin
                 accept     = 1'b1;
                 state_next = MAC;
               end
      MAC:     if (t == 3'd4) state_next = STORE;
      STORE:   state_next = (s == LAST_S) ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
    if (bus.flush) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  assign bus.in_ready = (state == IDLE);

  // Term t of section s: coefficient at s*5+t, data from the matching tap.
  always_comb begin
    c_sel = coef[CAW'(int'(s) * 5 + int'(t))];
    case (t)
      3'd0:    d_sel = x_cur;
      3'd1:    d_sel = x1[s];
      3'd2:    d_sel = x2[s];
      3'd3:    d_sel = y1[s];
      default: d_sel = y2[s];
    endcase
    prod     = {{DATA_W{c_sel[COEF_W-1]}}, c_sel} * {{COEF_W{d_sel[DATA_W-1]}}, d_sel};
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_base = (t == 3'd0) ? '0 : acc;
    acc_next = (t >= 3'd3) ? acc_base - prod_ext : acc_base + prod_ext;
    acc_rnd  = acc + RND;
    acc_shr  = acc_rnd >>> FRAC_BITS;
    if (acc_shr > SAT_MAX)      y_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_shr < SAT_MIN) y_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                        y_sat = acc_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= (i % 5 == 0) ? UNITY : '0;
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
      end
      x_cur         <= '0;
      acc           <= '0;
      s             <= '0;
      t             <= '0;
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.in_ready && bus.coef_we && (bus.coef_addr < NCOEF_A))
        coef[bus.coef_addr[CAW-1:0]] <= bus.coef_wdata;
      if (bus.flush) begin
        for (int i = 0; i < NUM_SECTIONS; i++) begin
          x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
        end
        t <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            x_cur <= bus.din;
            s     <= '0;
            t     <= '0;
          end
          MAC: begin
            acc <= acc_next;
            t   <= (t == 3'd4) ? 3'd0 : t + 3'd1;
          end
          STORE: begin
            x2[s] <= x1[s];
            x1[s] <= x_cur;
            y2[s] <= y1[s];
            y1[s] <= y_sat;
            x_cur <= y_sat;
            t     <= '0;
            if (s == LAST_S) begin
              bus.dout      <= y_sat;
              bus.out_valid <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_cascade.sv
`default_nettype none
// Bench for iir_biquad_cascade: cycle-level reference model plus literal
// expectations from hand-computed responses.
module tb_iir_biquad_cascade;
  localparam int DATA_W = 16, COEF_W = 16, FRAC_BITS = 14, NS = 4, ACC_W = 36;
  localparam int NC = 5 * NS;
  localparam int LAT = 6 * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_biquad_cascade_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

  iir_biquad_cascade #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS),
    .NUM_SECTIONS(NS), .ACC_W(ACC_W)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int ov_count = 0;

  // Reference model state
  int m_coef [NC];
  int mx1 [NS], mx2 [NS], my1 [NS], my2 [NS];
  int cnt, pend, exp_dout;
  bit exp_ov;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void clear_hist();
    for (int i = 0; i < NS; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? (1 << FRAC_BITS) : 0;
    clear_hist();
    cnt = 0; pend = 0; exp_dout = 0; exp_ov = 1'b0;
  endfunction

  // Whole-cascade response to one input sample, updating the histories.
  function automatic int model_filter(input int xin);
    int x, y;
    longint acc, r;
    x = xin;
    for (int k = 0; k < NS; k++) begin
      acc = longint'(m_coef[5*k]) * x + longint'(m_coef[5*k+1]) * mx1[k]
          + longint'(m_coef[5*k+2]) * mx2[k] - longint'(m_coef[5*k+3]) * my1[k]
          - longint'(m_coef[5*k+4]) * my2[k];
      r = (acc + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
      if (r > 32767) y = 32767;
      else if (r < -32768) y = -32768;
      else y = int'(r);
      mx2[k] = mx1[k]; mx1[k] = x;
      my2[k] = my1[k]; my1[k] = y;
      x = y;
    end
    return x;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        exp_ov = 1'b0;
        if (cnt == 0 && bus.coef_we && int'(bus.coef_addr) < NC)
          m_coef[int'(bus.coef_addr)] = int'(bus.coef_wdata);
        if (bus.flush) begin
          clear_hist();
          cnt = 0;
        end else if (cnt == 0) begin
          if (bus.in_valid) begin
            pend = model_filter(int'(bus.din));
            cnt  = LAT;
          end
        end else begin
          cnt--;
          if (cnt == 0) begin
            exp_ov   = 1'b1;
            exp_dout = pend;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.out_valid) ov_count++;
    if (chk_en) begin
      chk("in_ready", longint'(bus.in_ready), longint'(cnt == 0));
      chk("out_valid", longint'(bus.out_valid), longint'(exp_ov));
      chk("dout", longint'(bus.dout), longint'(exp_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 8'(addr);
    bus.coef_wdata = 16'(val);
    tick();
    bus.coef_we    = 1'b0;
  endtask

  task automatic wait_out(input int maxc, output int lat, output int val);
    lat = -1;
    val = 0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (bus.out_valid) begin
        lat = k;
        val = int'(bus.dout);
        break;
      end
    end
  endtask

  task automatic send(input int v, output int lat, output int val);
    bus.in_valid = 1'b1;
    bus.din      = 16'(v);
    tick();
    bus.in_valid = 1'b0;
    wait_out(40, lat, val);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic load_lowpass();
    write_coef(0, 167);
    write_coef(1, -302);
    write_coef(2, 167);
    write_coef(3, -31881);
    write_coef(4, 15531);
  endtask

  initial begin
    int lat, v, n, last, ov0, tmp;
    bit rdy;
    bus.in_valid = 1'b0; bus.din = '0; bus.flush = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    chk("reset_in_ready", longint'(bus.in_ready), 1);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_dout", longint'(bus.dout), 0);

    send(1000, lat, v);
    chk("pass_latency", lat, 24);
    chk("pass_1000", v, 1000);
    send(-32768, lat, v);
    chk("pass_min", v, -32768);

    load_lowpass();
    pulse_flush();
    send(16384, lat, v);
    chk("lp_y0", v, 167);
    send(0, lat, v);
    chk("lp_y1", v, 23);
    for (int i = 0; i < 6; i++) send(0, lat, v);

    pulse_flush();
    write_coef(0, 32767);
    for (int i = 1; i < 5; i++) write_coef(i, 0);
    send(30000, lat, v);
    chk("sat_pos", v, 32767);
    send(-30000, lat, v);
    chk("sat_neg", v, -32768);

    write_coef(0, 16384);
    ov0 = ov_count;
    bus.in_valid = 1'b1;
    bus.din = 16'(100);
    n = 0;
    last = 0;
    for (int k = 0; k < 400 && n < 8; k++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        if (n > 0) chk("b2b_interval", k - last, 25);
        last = k;
        n++;
        bus.din = bus.din + 16'sd1;
      end
    end
    bus.in_valid = 1'b0;
    repeat (30) tick();
    chk("b2b_accepts", n, 8);
    chk("b2b_outputs", ov_count - ov0, 8);

    bus.in_valid = 1'b1;
    bus.din = 16'(500);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.coef_we = 1'b1; bus.coef_addr = 8'd0; bus.coef_wdata = '0;
    tick();
    bus.coef_we = 1'b0;
    wait_out(40, lat, v);
    chk("busy_write_latency", lat, 19);
    chk("busy_write_dropped", v, 500);
    write_coef(0, 0);
    send(700, lat, v);
    chk("idle_write_zero", v, 0);
    write_coef(0, 16384);

    load_lowpass();
    pulse_flush();
    bus.in_valid = 1'b1;
    bus.din = 16'(16384);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ready", longint'(bus.in_ready), 1);
    wait_out(30, lat, v);
    chk("flush_no_out", lat, -1);
    send(16384, lat, v);
    chk("flush_lp_y0", v, 167);
    send(0, lat, v);
    chk("flush_lp_y1", v, 23);

    bus.in_valid = 1'b1;
    bus.din = 16'(16384);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_dout", longint'(bus.dout), 0);
    tick();
    tick();
    rst = 1'b0;
    send(1234, lat, v);
    chk("midrst_passthrough", v, 1234);

    for (int k = 0; k < 4000; k++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.din      = 16'($urandom);
      bus.coef_we  = ($urandom_range(0, 15) == 0);
      bus.coef_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NC - 1));
      tmp = int'($urandom_range(0, 32767)) - 16384;
      bus.coef_wdata = 16'(tmp);
      bus.flush    = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.coef_we = 1'b0; bus.flush = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised successor to the single-section DF1 biquad: a cascade of `NUM_SECTIONS` direct-form-I biquad sections sharing one time-multiplexed multiplier and accumulator. Coefficients are runtime-writable, arithmetic rounds and saturates, and samples move through a valid/ready handshake. It sits between the ADC sample stream and downstream decimation/DSP, replacing fixed single-section filters where a higher filter order is needed.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed.
- `COEF_W`, 16: coefficient width, signed.
- `FRAC_BITS`, 14: coefficient fractional bits. Must satisfy `FRAC_BITS <= COEF_W-2`.
- `NUM_SECTIONS`, 4: number of cascaded biquads, 1..16.
- `ACC_W`, 36: accumulator width. Must satisfy `ACC_W >= DATA_W+COEF_W+3`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `din` is valid.
- `in_ready` out 1: block is idle and accepts a sample.
- `din` in DATA_W: input sample, signed.
- `out_valid` out 1: one-cycle pulse; `dout` holds a new result.
- `dout` out DATA_W: filtered sample, signed. Holds its value between pulses.
- `flush` in 1: synchronous clear of all delay state; aborts any in-flight sample.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in 8: write address, `section*5 + idx`, where idx is 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- `coef_wdata` in COEF_W: coefficient value, signed, Q(`FRAC_BITS`).

## Operation
- **Coefficient storage:** `5*NUM_SECTIONS` registers. Any gain is folded into the b coefficients. a1 and a2 are stored with their natural sign; the datapath subtracts their products.
- **Reset values:**
  - Every section is passthrough: b0 = 2^FRAC_BITS, all other coefficients 0.
  - All delay state is 0.
  - `in_ready`=1, `out_valid`=0, `dout`=0. FSM in IDLE.
- **Per-section delay state:** x1, x2, y1, y2, each DATA_W bits.
- **FSM states:**
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `din` as the section-0 input x, set section index s=0 and term index t=0, then go to MAC.
  - MAC (5 cycles per section): acc <= (t==0 ? 0 : acc) + term(t), where the terms are b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2. After t=4, go to STORE.
  - STORE (1 cycle):
    - y = sat_DATA_W((acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS), with an arithmetic shift.
    - Update section s: x2<=x1, x1<=x, y2<=y1, y1<=y.
    - The next section's x <= y.
    - If s < NUM_SECTIONS−1: s++ and return to MAC. Otherwise `dout`<=y, pulse `out_valid`, go to IDLE.
- **Widths:**
  - Each product is DATA_W+COEF_W bits, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W; the guard bits make this unreachable for in-range coefficients.
  - Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- **Coefficient writes:**
  - Accepted only in a cycle where `in_ready`=1.
  - Writes while busy are dropped.
  - Addresses >= 5·NUM_SECTIONS are ignored.
  - Delay state is not cleared by a write.
- **Flush:**
  - Zeroes all x1/x2/y1/y2 and returns the FSM to IDLE.
  - No `out_valid` is produced for an aborted sample; `dout` is unchanged.
  - Coefficients are preserved.
  - `flush` has priority over `in_valid` in the same cycle; that sample is not accepted.
- **Mid-operation reset:** `rst` asserted during processing discards the sample and restores all reset values, including coefficients.

## Timing
- Acceptance edge is E0.
  - Section k MAC occupies edges E(6k+1)..E(6k+5).
  - Section k STORE occurs at E(6k+6).
- `out_valid` and the new `dout` are visible after edge E(6·NUM_SECTIONS). For the default (4 sections) this is 24 cycles after acceptance.
- `in_ready` is high in the same cycle as `out_valid`, so the minimum sample period is 6·NUM_SECTIONS+1 cycles (25 for the default).
- `in_ready` is low from the cycle after E0 until the cycle of `out_valid`.

## Test plan
- **Reset passthrough:** after reset, accept `din`=1000 → `out_valid` exactly 24 cycles later, `dout`=1000. Then `din`=−32768 → `dout`=−32768.
- **Lowpass impulse response:**
  - Write section 0 with b0=167, b1=−302, b2=167, a1=−31881, a2=15531; leave other sections passthrough.
  - Stimulus: `din`=16384, then zeros.
  - Required output: `dout` sequence starts 167, 23, …; compare against a bit-exact rounding/saturating reference model.
- **Saturation:** set section 0 b0=32767, `din`=30000 → `dout`=32767. Set `din`=−30000 → `dout`=−32768.
- **Back-to-back throughput:** hold `in_valid`=1 with an incrementing `din` → accepts exactly every 25 cycles, one `out_valid` per accept, no drops.
- **Coefficient write while busy:** write b0=0 to section 0 at E5 of a sample → write ignored, output unchanged. The same write while idle → subsequent outputs are 0.
- **Flush and reset mid-sample:**
  - `flush` at E10 → no `out_valid`, `in_ready`=1 next cycle, and the next impulse response matches one from zero state.
  - `rst` at E10 → all outputs at reset values, coefficients back to passthrough.
